// File: rtl/countdown_timer_k.sv
// Loadable modulo-K down-counter with one-cycle borrow pulse, one-shot or periodic reload.
// Define COUNTDOWN_PRESCALE_EN to count only every PRESCALE-th enabled cycle.
module countdown_timer_k #(
  parameter int K = 20
`ifdef COUNTDOWN_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
  , localparam int N = $clog2(K)
) (
  input  logic         clk,
  input  logic         aclr_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         enable,
  input  logic         periodic,
  output logic [N-1:0] q,
  output logic         borrow,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [N-1:0] Q_MAX = N'(K - 1);

  state_t       state;
  logic [N-1:0] reload;
  logic         mode;
  logic         tick;

  function automatic logic [N-1:0] clamp_k(input logic [N-1:0] v);
    return (v > Q_MAX) ? Q_MAX : v;
  endfunction

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = enable && (pre_cnt == PRE_LAST);

  // Divider only advances on enabled RUN cycles and restarts from zero on every load.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      pre_cnt <= '0;
    end else if (load || (state != RUN)) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign tick = enable;
`endif

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      q      <= '0;
      reload <= '0;
      mode   <= 1'b0;
      borrow <= 1'b0;
      state  <= IDLE;
    end else if (load) begin
      q      <= clamp_k(load_val);
      reload <= clamp_k(load_val);
      mode   <= periodic;
      borrow <= 1'b0;
      state  <= RUN;
    end else begin
      borrow <= 1'b0;
      if ((state == RUN) && tick) begin
        if (q != '0) begin
          q <= q - 1'b1;
        end else begin
          // Terminal count: pulse, then reload or stop with q parked at zero.
          borrow <= 1'b1;
          if (mode) q <= reload;
          else      state <= IDLE;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule
